// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: address/data widths plus the memory arbiter's
// byte-enable and owner types.
package riscv;

  typedef logic [11:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  be_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data ports, with
// fixed read latency and a starvation guard that eventually lets fetch win.
//
// state | meaning
// IDLE  | memory free; at most one grant per cycle, writes finish here
// WAIT  | read in flight for the registered owner; no grants issued
module mem_arbiter
  import riscv::*;
#(
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  addr_t       if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output data_t       if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  addr_t       d_addr,
  input  data_t       d_wdata,
  input  be_t         d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output data_t       d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output addr_t       mem_addr,
  output data_t       mem_wdata,
  output be_t         mem_be,
  input  data_t       mem_rdata
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  localparam logic [2:0] LAT_LOAD   = 3'(LATENCY);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state, state_nxt;
  arb_owner_t owner, owner_nxt;
  logic [2:0] lat_cnt, lat_cnt_nxt;
  logic [3:0] starve_cnt, starve_cnt_nxt;
  logic       rd_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      lat_cnt    <= lat_cnt_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    lat_cnt_nxt    = lat_cnt;
    starve_cnt_nxt = starve_cnt;
    if_gnt         = 1'b0;
    d_gnt          = 1'b0;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_be         = '0;
    rd_done        = 1'b0;

    // rst_n gating keeps grants and the memory strobe quiet while held in reset
    if (state == IDLE && rst_n) begin
      if (d_req && starve_cnt < STARVE_LIM) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end

    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
      if (!d_we) begin
        state_nxt   = WAIT;
        owner_nxt   = OWN_D;
        lat_cnt_nxt = LAT_LOAD;
      end
    end else if (if_gnt) begin
      mem_en      = 1'b1;
      mem_addr    = if_addr;
      mem_be      = 4'hF;
      state_nxt   = WAIT;
      owner_nxt   = OWN_IF;
      lat_cnt_nxt = LAT_LOAD;
    end

    // the counter hits 0 on this cycle's decrement, so data returns now
    if (state == WAIT) begin
      lat_cnt_nxt = lat_cnt - 3'd1;
      if (lat_cnt == 3'd1) begin
        rd_done   = 1'b1;
        state_nxt = IDLE;
      end
    end

    if (!if_req || if_gnt) begin
      starve_cnt_nxt = '0;
    end else if (state == IDLE && starve_cnt < STARVE_LIM) begin
      starve_cnt_nxt = starve_cnt + 4'd1;
    end
  end

  assign if_rvalid = rd_done && (owner == OWN_IF);
  assign d_rvalid  = rd_done && (owner == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Random and directed bench for mem_arbiter: two instances (LATENCY 1 and 3)
// share stimulus and are compared every cycle against a cycle-budget model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [11:0] if_addr, d_addr;
  logic [31:0] d_wdata, mem_rdata;
  logic [3:0]  d_be;

  logic [1:0]  if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata [2];
  logic [31:0] d_rdata [2];
  logic [31:0] mem_wdata [2];
  logic [11:0] mem_addr [2];
  logic [3:0]  mem_be [2];

  int n_chk  = 0;
  int n_pass = 0;

  // model: remaining read cycles, starvation count, read owner per instance
  int rem [2];
  int starve [2];
  bit own_d [2];
  bit e_dg [2];
  bit e_ig [2];
  bit e_free [2];

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(1), .STARVE_MAX(4)) u0 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_be(mem_be[0]), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.LATENCY(3), .STARVE_MAX(2)) u1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_be(mem_be[1]), .mem_rdata(mem_rdata)
  );

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int sm_of(int k);
    return (k == 0) ? 4 : 2;
  endfunction

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  task automatic sample();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bit rv;
      if (!rst_n) begin
        rem[k] = 0;
        starve[k] = 0;
        own_d[k] = 1'b0;
      end
      e_free[k] = (rem[k] == 0);
      e_dg[k] = rst_n && e_free[k] && d_req && (starve[k] < sm_of(k));
      e_ig[k] = rst_n && e_free[k] && if_req && !e_dg[k];
      rv = (rem[k] == 1);
      check($sformatf("u%0d if_gnt", k), 32'(if_gnt[k]), 32'(e_ig[k]));
      check($sformatf("u%0d d_gnt", k), 32'(d_gnt[k]), 32'(e_dg[k]));
      check($sformatf("u%0d if_rvalid", k), 32'(if_rvalid[k]), 32'(rv && !own_d[k]));
      check($sformatf("u%0d d_rvalid", k), 32'(d_rvalid[k]), 32'(rv && own_d[k]));
      check($sformatf("u%0d if_rdata", k), if_rdata[k], (rv && !own_d[k]) ? mem_rdata : 32'h0);
      check($sformatf("u%0d d_rdata", k), d_rdata[k], (rv && own_d[k]) ? mem_rdata : 32'h0);
      check($sformatf("u%0d mem_en", k), 32'(mem_en[k]), 32'(e_dg[k] || e_ig[k]));
      check($sformatf("u%0d mem_we", k), 32'(mem_we[k]), 32'(e_dg[k] && d_we));
      check($sformatf("u%0d mem_addr", k), 32'(mem_addr[k]),
            32'(e_dg[k] ? d_addr : (e_ig[k] ? if_addr : 12'h0)));
      check($sformatf("u%0d mem_wdata", k), mem_wdata[k], e_dg[k] ? d_wdata : 32'h0);
      check($sformatf("u%0d mem_be", k), 32'(mem_be[k]),
            32'(e_dg[k] ? d_be : (e_ig[k] ? 4'hF : 4'h0)));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst_n) begin
        if (e_dg[k] && !d_we) begin
          rem[k] = lat_of(k);
          own_d[k] = 1'b1;
        end else if (e_ig[k]) begin
          rem[k] = lat_of(k);
          own_d[k] = 1'b0;
        end else if (rem[k] > 0) begin
          rem[k]--;
        end
        if (!if_req || e_ig[k]) starve[k] = 0;
        else if (e_free[k] && starve[k] < sm_of(k)) starve[k]++;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    sample();
    advance();
    rst_n = 1;
  endtask

  function automatic int activity(int k);
    return int'(mem_en[k]) + int'(if_gnt[k]) + int'(d_gnt[k]) +
           int'(if_rvalid[k]) + int'(d_rvalid[k]);
  endfunction

  initial begin
    int nd, ig_at, gsum, rv_at, cnt;

    // reset with both requests active: grants must stay low
    idle_inputs();
    rst_n = 0;
    if_req = 1; d_req = 1;
    sample();
    check("rst if_gnt", 32'(if_gnt[0]), 32'h0);
    check("rst d_gnt", 32'(d_gnt[0]), 32'h0);
    advance();
    rst_n = 1;

    // fetch-only read, first cycle after reset
    do_reset();
    if_req = 1; if_addr = 12'h010; mem_rdata = 32'h00000013;
    sample();
    check("fetch gnt", 32'(if_gnt[0]), 32'h1);
    check("fetch mem_en", 32'(mem_en[0]), 32'h1);
    advance();
    if_req = 0;
    sample();
    check("fetch rvalid", 32'(if_rvalid[0]), 32'h1);
    check("fetch rdata", if_rdata[0], 32'h00000013);
    check("fetch d_rvalid", 32'(d_rvalid[0]), 32'h0);
    advance();

    // simultaneous write vs fetch
    do_reset();
    if_req = 1; d_req = 1; d_we = 1; d_addr = 12'h100; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
    sample();
    check("simul d_gnt", 32'(d_gnt[0]), 32'h1);
    check("simul if_gnt", 32'(if_gnt[0]), 32'h0);
    check("simul mem_we", 32'(mem_we[0]), 32'h1);
    check("simul mem_be", 32'(mem_be[0]), 32'h3);
    advance();
    d_req = 0;
    sample();
    check("simul next if_gnt", 32'(if_gnt[0]), 32'h1);
    advance();

    // starvation: data wins STARVE_MAX times, then fetch
    do_reset();
    if_req = 1; d_req = 1; d_we = 1; d_addr = 12'h200; d_wdata = 32'h1; d_be = 4'hF;
    nd = 0; ig_at = -1;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (if_gnt[0]) begin
        ig_at = i;
        advance();
        break;
      end
      if (d_gnt[0]) nd++;
      advance();
    end
    check("starve d_gnt count", 32'(nd), 32'd4);
    check("starve if_gnt cycle", 32'(ig_at), 32'd4);
    sample();
    advance();
    sample();
    check("starve cleared d_gnt", 32'(d_gnt[0]), 32'h1);
    advance();

    // LATENCY=3 data read holding off a waiting fetch
    do_reset();
    d_req = 1; d_we = 0; d_addr = 12'h020;
    sample();
    check("lat3 d_gnt", 32'(d_gnt[1]), 32'h1);
    advance();
    d_req = 0; if_req = 1; if_addr = 12'h040;
    gsum = 0; rv_at = -1;
    for (int c = 1; c <= 4; c++) begin
      mem_rdata = $urandom;
      sample();
      if (c < 4) gsum += int'(if_gnt[1]) + int'(d_gnt[1]);
      if (d_rvalid[1]) rv_at = c;
      if (c == 4) check("lat3 if_gnt c4", 32'(if_gnt[1]), 32'h1);
      advance();
    end
    check("lat3 no grant in wait", 32'(gsum), 32'd0);
    check("lat3 rvalid cycle", 32'(rv_at), 32'd3);

    // reset during a LATENCY=3 read
    do_reset();
    d_req = 1; d_we = 0; d_addr = 12'h020;
    sample();
    advance();
    rst_n = 0;
    d_req = 1; if_req = 1;
    sample();
    check("rst mid-read activity", 32'(activity(1)), 32'd0);
    check("rst mid-read mem_addr", 32'(mem_addr[1]), 32'h0);
    advance();
    rst_n = 1;
    idle_inputs();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      mem_rdata = $urandom;
      sample();
      cnt += int'(if_rvalid[1]) + int'(d_rvalid[1]);
      advance();
    end
    check("rst discard rvalid", 32'(cnt), 32'd0);

    // idle
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      sample();
      cnt += activity(0) + activity(1);
      advance();
    end
    check("idle activity", 32'(cnt), 32'd0);

    // random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 79) != 0);
      if_req    = ($urandom_range(0, 9) < 6);
      d_req     = ($urandom_range(0, 9) < 5);
      d_we      = $urandom_range(0, 1);
      if_addr   = 12'($urandom);
      d_addr    = 12'($urandom);
      d_wdata   = $urandom;
      d_be      = 4'($urandom);
      mem_rdata = $urandom;
      sample();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
